// File: rtl/hcsr04_echo_emulator.sv
// -----------------------------------------------------------------------------
// hcsr04_echo_emulator
// Synthesisable stand-in for the responder end of an HC-SR04 ultrasonic
// ranging module. It watches the trigger line and checks that the trigger is
// wide enough. It then waits the burst delay and drives echo high for a width
// set by distance_mm. A sensor controller can therefore run in simulation or in
// on-board loopback without the real part.
//
// Optional feature macro: HCSR04_EMU_HOLDOFF_EN
//   defined   : after echo falls, stay busy for HOLDOFF_CYCLES. Triggers there
//               are ignored, and every rising edge pulses trig_err.
//   undefined : ECHO returns straight to IDLE on the cycle echo falls.
//
// Ports
//   clk          in   system clock (50 MHz nominal)
//   rst_n        in   asynchronous active-low reset
//   trigger      in   trigger from controller, asynchronous, synchronised here
//   distance_mm  in   target distance in mm, latched at accepted trigger fall
//   echo         out  registered echo pulse
//   busy         out  high whenever the FSM is not in IDLE
//   trig_err     out  one-cycle pulse on a rejected (short / holdoff) trigger
// -----------------------------------------------------------------------------
module hcsr04_echo_emulator #(
  parameter int unsigned CYCLES_PER_MM   = 294,
  parameter int unsigned TRIG_MIN_CYCLES = 500,
  parameter int unsigned BURST_CYCLES    = 10000,
  parameter int unsigned MAX_MM          = 4000,
  parameter int unsigned NO_OBJ_CYCLES   = 1900000,
  parameter int unsigned HOLDOFF_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [15:0] distance_mm,
  output logic        echo,
  output logic        busy,
  output logic        trig_err
);

`ifdef HCSR04_EMU_HOLDOFF_EN
  localparam bit HOLDOFF_EN = 1'b1;
`else
  localparam bit HOLDOFF_EN = 1'b0;
`endif

  localparam logic [31:0] CPM_W      = 32'(CYCLES_PER_MM);
  localparam logic [31:0] TRIG_MIN_W = 32'(TRIG_MIN_CYCLES);
  localparam logic [31:0] BURST_W    = 32'(BURST_CYCLES);
  localparam logic [15:0] MAX_MM_W   = 16'(MAX_MM);
  localparam logic [31:0] NO_OBJ_W   = 32'(NO_OBJ_CYCLES);
  localparam logic [31:0] HOLDOFF_W  = 32'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // shared: trigger width / burst / echo / holdoff
  logic [31:0] width_q, width_d;   // echo width latched at accepted trigger fall
  logic        echo_q, echo_d;
  logic        trig_err_q, trig_err_d;

  // Two-flop synchroniser plus one history flop used for edge detection.
  logic        trig_s1_q, trig_s2_q, trig_prev_q;
  logic        trig_rise, trig_fall;
  logic [31:0] dist_width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s1_q   <= trigger;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
    end
  end

  assign trig_rise = trig_s2_q & ~trig_prev_q;
  assign trig_fall = ~trig_s2_q & trig_prev_q;

  // Max in-range product is MAX_MM*CYCLES_PER_MM (1,176,000 by default), so
  // the product fits in 32 bits.
  assign dist_width = ((distance_mm == 16'd0) || (distance_mm > MAX_MM_W))
                      ? NO_OBJ_W
                      : 32'(distance_mm) * CPM_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      echo_q     <= 1'b0;
      trig_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      echo_q     <= echo_d;
      trig_err_q <= trig_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    echo_d     = 1'b0;
    trig_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only a fresh rising edge starts a measurement. A trigger that is
        // still high when the FSM returns here is ignored until it toggles.
        if (trig_rise) begin
          state_d = S_TRIG_HI;
          cnt_d   = 32'd1;
        end
      end
      S_TRIG_HI: begin
        if (trig_fall) begin
          cnt_d = '0;
          if (cnt_q >= TRIG_MIN_W) begin
            width_d = dist_width;
            state_d = S_BURST;
          end else begin
            trig_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (cnt_q < TRIG_MIN_W) begin
          // Saturate so that a very long trigger cannot wrap back to short.
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_BURST: begin
        // Stay here for BURST_CYCLES counted cycles. echo rises on the cycle
        // after the count completes, which keeps the trigger-to-echo latency
        // fixed.
        if (cnt_q >= BURST_W) begin
          state_d = S_ECHO;
          cnt_d   = 32'd1;
          echo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ECHO: begin
        // cnt_q is the number of echo-high cycles already driven.
        if (cnt_q >= width_q) begin
          cnt_d   = '0;
          state_d = HOLDOFF_EN ? S_HOLDOFF : S_IDLE;
        end else begin
          cnt_d  = cnt_q + 32'd1;
          echo_d = 1'b1;
        end
      end
      S_HOLDOFF: begin
        trig_err_d = trig_rise;
        if (cnt_q + 32'd1 >= HOLDOFF_W) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign echo     = echo_q;
  assign busy     = (state_q != S_IDLE);
  assign trig_err = trig_err_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// -----------------------------------------------------------------------------
// tb_hcsr04_echo_emulator
// Self-checking bench with scaled-down timing parameters. Directed scenarios
// cover the boundary cases, and a randomised loop follows them. Expected echo
// width, latency and trig_err behaviour come from the rules for distance and
// trigger width, written as plain arithmetic.
// -----------------------------------------------------------------------------
module tb_hcsr04_echo_emulator;
  localparam int CPM   = 3;
  localparam int TMIN  = 8;
  localparam int BURST = 20;
  localparam int MAXMM = 50;
  localparam int NOOBJ = 200;
  localparam int HOLD  = 100;
  // Latency from trigger fall at the pin to echo rise:
  // 2 sync + 1 edge + BURST + 1 cycles.
  localparam int LAT   = 2 + 1 + BURST + 1;
`ifdef HCSR04_EMU_HOLDOFF_EN
  localparam bit HO = 1'b1;
`else
  localparam bit HO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] distance_mm = 16'd0;
  logic        echo, busy, trig_err;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;

  hcsr04_echo_emulator #(
    .CYCLES_PER_MM(CPM), .TRIG_MIN_CYCLES(TMIN), .BURST_CYCLES(BURST),
    .MAX_MM(MAXMM), .NO_OBJ_CYCLES(NOOBJ), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .distance_mm(distance_mm),
    .echo(echo), .busy(busy), .trig_err(trig_err)
  );

  always #5 clk = ~clk;

  // Count the cycles on which trig_err is high. A single pulse adds exactly 1.
  always @(negedge clk) if (trig_err === 1'b1) err_pulses++;

  function automatic int exp_width(input int d);
    return (d == 0 || d > MAXMM) ? NOOBJ : d * CPM;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 5000) begin tick(); k++; end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  // One measurement: trigger held high for `hi` cycles at distance d. If
  // chg_at >= 0, distance_mm changes to new_d that many cycles into the echo.
  task automatic meas(input int d, input int hi, input int new_d, input int chg_at);
    int e0, lat, w, seen;
    e0 = err_pulses;
    seen = 0;
    distance_mm = 16'(d);
    trigger = 1'b1;
    for (int i = 0; i < hi; i++) begin tick(); if (echo) seen = 1; end
    trigger = 1'b0;
    chk("echo_during_trig", seen, 0);
    if (hi >= TMIN) begin
      lat = 0;
      while (echo !== 1'b1 && lat < 1000) begin
        tick(); lat++;
        if (lat == LAT / 2) chk("busy_burst", {31'd0, busy}, 1);
      end
      chk("latency", lat, LAT);
      w = 0;
      while (echo === 1'b1 && w < 1000) begin
        if (w == chg_at) distance_mm = 16'(new_d);
        tick(); w++;
      end
      chk("width", w, exp_width(d));
      chk("busy_after_echo", {31'd0, busy}, {31'd0, HO});
      chk("no_err", err_pulses - e0, 0);
    end else begin
      seen = 0;
      for (int i = 0; i < LAT + NOOBJ; i++) begin tick(); if (echo) seen = 1; end
      chk("rej_echo", seen, 0);
      chk("rej_err", err_pulses - e0, 1);
      chk("rej_busy", {31'd0, busy}, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int e0, seen, k, d, hi, r;
    // Reset state
    tick(3);
    chk("rst_echo", {31'd0, echo}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, trig_err}, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic, no-object and boundary distances
    meas(10, TMIN, 0, -1);
    meas(0, TMIN + 5, 0, -1);
    meas(MAXMM + 1, TMIN, 0, -1);
    meas(MAXMM, TMIN, 0, -1);
    wait_idle();
    meas(1, TMIN, 0, -1);
    wait_idle();

    // Short triggers are rejected
    meas(5, TMIN - 1, 0, -1);
    meas(5, 3, 0, -1);

    // Distance change during the echo does not affect the pulse in flight
    meas(25, TMIN + 2, 5, 10);
    wait_idle();
    meas(5, TMIN, 0, -1);
    wait_idle();

    // Reset in the middle of the echo
    distance_mm = 16'd20;
    trigger = 1'b1; tick(TMIN); trigger = 1'b0;
    tick(LAT + 10);
    chk("echo_pre_rst", {31'd0, echo}, 1);
    rst_n = 1'b0; #1;
    chk("echo_async_rst", {31'd0, echo}, 0);
    tick(10);
    chk("busy_in_rst", {31'd0, busy}, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 100; i++) begin tick(); if (echo) seen = 1; end
    chk("no_echo_after_rst", seen, 0);
    meas(7, TMIN, 0, -1);

    // Retrigger shortly after the echo falls
    tick(HOLD / 2);
    if (HO) begin
      e0 = err_pulses;
      trigger = 1'b1; tick(TMIN + 2); trigger = 1'b0;
      seen = 0;
      for (int i = 0; i < LAT + 50; i++) begin tick(); if (echo) seen = 1; end
      chk("holdoff_echo", seen, 0);
      chk("holdoff_err", err_pulses - e0, 1);
    end else begin
      meas(12, TMIN, 0, -1);
    end
    wait_idle();

    // Trigger still high when the FSM returns to idle: no new measurement
    distance_mm = 16'd5;
    trigger = 1'b1; tick(TMIN); trigger = 1'b0;
    k = 0;
    while (echo !== 1'b1 && k < 1000) begin tick(); k++; end
    chk("held_lat", k, LAT);
    e0 = err_pulses;
    trigger = 1'b1;
    wait_idle();
    tick(5);
    trigger = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 50; i++) begin tick(); if (echo || busy) seen = 1; end
    chk("held_no_meas", seen, 0);
    chk("held_no_err", err_pulses - e0, 0);

    // Randomised measurements
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      d = 0;
      else if (r == 1) d = MAXMM + 1 + int'($urandom_range(0, 1000));
      else if (r == 2) d = MAXMM;
      else             d = int'($urandom_range(1, MAXMM));
      hi = int'($urandom_range(TMIN - 3, TMIN + 6));
      if ($urandom_range(0, 1) == 1)
        meas(d, hi, int'($urandom_range(0, 65535)), int'($urandom_range(0, 10)));
      else
        meas(d, hi, 0, -1);
      wait_idle();
      tick(int'($urandom_range(1, 5)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
